// File: rtl/fetch_mem_arbiter_pkg.sv
// Shared widths and types for the instruction-side fetch arbiter.
// Requester tags carry {opcode, mshr index, txn id}; memory tags prepend the requester id.
package fetch_mem_arbiter_pkg;

    localparam int ADDR_WIDTH              = 32;
    localparam int FETCH_DATA_WIDTH        = 64;
    localparam int ICACHE_REQ_OPCODE_WIDTH = 2;
    localparam int MSHR_ENTRY_INDEX_WIDTH  = 2;
    localparam int ROB_ENTRY_ID_WIDTH      = 4;

    localparam int FETCH_ARB_NUM_REQ   = 2;
    localparam int FETCH_ARB_TAG_WIDTH = ICACHE_REQ_OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH
                                       + ROB_ENTRY_ID_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]          addr;
        logic [FETCH_ARB_TAG_WIDTH-1:0] tag;
    } fetch_arb_req_t;

endpackage

// File: rtl/fetch_arb_rr2.sv
// Two-way round-robin grant; the pointer moves past the winner only when a grant is accepted.
module fetch_arb_rr2
    import fetch_mem_arbiter_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FETCH_ARB_NUM_REQ-1:0] req_i,
    input  logic                         en_i,
    output logic [FETCH_ARB_NUM_REQ-1:0] rdy_o
);

    logic                         ptr_q;
    logic                         ptr_d;
    logic [FETCH_ARB_NUM_REQ-1:0] grant;
    logic                         accept;

    always_comb begin
        grant = req_i;
        if (req_i == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end
    end

    assign rdy_o  = en_i ? grant : 2'b00;
    assign accept = |(req_i & rdy_o);
    assign ptr_d  = accept ? ~rdy_o[1] : ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates the ICache miss path and the prefetcher onto one memory fetch port,
// with a one-entry output register, credit-limited issue and tag-routed responses.
module fetch_mem_arbiter
    import fetch_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W          = ADDR_WIDTH,
    parameter int TAG_W           = ICACHE_REQ_OPCODE_WIDTH + MSHR_ENTRY_INDEX_WIDTH
                                  + ROB_ENTRY_ID_WIDTH,
    parameter int DATA_W          = FETCH_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [FETCH_ARB_NUM_REQ-1:0]          req_vld,
    output logic [FETCH_ARB_NUM_REQ-1:0]          req_rdy,
    input  logic [FETCH_ARB_NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [FETCH_ARB_NUM_REQ-1:0][TAG_W-1:0]  req_tag,
    output logic [FETCH_ARB_NUM_REQ-1:0]          ack_vld,
    input  logic [FETCH_ARB_NUM_REQ-1:0]          ack_rdy,
    output logic [DATA_W-1:0]                     ack_data,
    output logic [TAG_W-1:0]                      ack_tag,
    output logic                                  mem_req_vld,
    input  logic                                  mem_req_rdy,
    output logic [ADDR_W-1:0]                     mem_req_addr,
    output logic [TAG_W:0]                        mem_req_tag,
    input  logic                                  mem_ack_vld,
    output logic                                  mem_ack_rdy,
    input  logic [DATA_W-1:0]                     mem_ack_data,
    input  logic [TAG_W:0]                        mem_ack_tag,
    output logic [CNT_W-1:0]                      outstanding,
    output logic                                  err_underflow
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic              vld_q, vld_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TAG_W:0]    tag_q, tag_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    logic slot_free;
    logic can_issue;
    logic up_fire;
    logic win_id;
    logic ack_id;
    logic ack_fire;

    assign slot_free = !vld_q || mem_req_rdy;
    assign can_issue = slot_free && (cnt_q < MAX_CNT);

    fetch_arb_rr2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_vld),
        .en_i  (can_issue),
        .rdy_o (req_rdy)
    );

    assign up_fire = |(req_vld & req_rdy);
    assign win_id  = req_rdy[1];

    // Output stage: hold until drained, refill in the same cycle as a drain.
    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        tag_d  = tag_q;
        if (up_fire) begin
            vld_d  = 1'b1;
            addr_d = req_addr[win_id];
            tag_d  = {win_id, req_tag[win_id]};
        end else if (mem_req_rdy) begin
            vld_d  = 1'b0;
        end
    end

    // Responses are routed by the requester id echoed in the top tag bit.
    assign ack_id      = mem_ack_tag[TAG_W];
    assign ack_vld     = mem_ack_vld ? (ack_id ? 2'b10 : 2'b01) : 2'b00;
    assign mem_ack_rdy = ack_rdy[ack_id];
    assign ack_data    = mem_ack_data;
    assign ack_tag     = mem_ack_tag[TAG_W-1:0];
    assign ack_fire    = mem_ack_vld && mem_ack_rdy;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        unique case ({up_fire, ack_fire})
            2'b10: cnt_d = cnt_q + CNT_W'(1);
            2'b01: begin
                if (cnt_q == '0) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= 1'b0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Address and tag are only meaningful while vld_q is set, so they skip reset.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        tag_q  <= tag_d;
    end

    assign mem_req_vld   = vld_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_tag   = tag_q;
    assign outstanding   = cnt_q;
    assign err_underflow = err_q;

endmodule
